ls_ou: RTL and testbench

- Parametrised load/store operation unit for the RCA fabric; the successor to the fixed store-byte OU.
- Compile-time selects load or store mode and access width (B/H/W).
- Issues requests to the LSQ and tracks outstanding loads with a credit counter.
- Buffers returned load data in a response FIFO and forwards it to the downstream OU with a valid/ack handshake.

---
 rtl/ls_ou.sv | 157 +++++++++++++++
 tb/tb_ls_ou.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_ou.sv
// rtl/ls_ou.sv - parametrised load/store OU with credit-limited LSQ issue and response FIFO
// Optional store-completion tokens: RCA_LS_STORE_TOKEN_EN
module ls_ou #(
    parameter int         XLEN            = 32,
    parameter bit         IS_STORE        = 1'b0,
    parameter logic [2:0] ACCESS_FN3      = 3'b010,
    parameter int         MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] data_in1,
    input  logic [XLEN-1:0] data_in2,
    input  logic            data_valid_in1,
    input  logic            data_valid_in2,
    output logic            data_in_ack1,
    output logic            data_in_ack2,
    output logic            uses_data_in1,
    output logic            uses_data_in2,
    output logic [XLEN-1:0] data_out,
    output logic            data_valid_out,
    input  logic            data_out_ack,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic [2:0]      fn3,
    output logic            load,
    output logic            store,
    output logic            new_request,
    input  logic            lsq_full,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_complete,
    output logic            protocol_err
);
    localparam logic [2:0] LS_B_fn3  = 3'b000;
    localparam logic [2:0] LS_H_fn3  = 3'b001;
    localparam logic [2:0] LS_W_fn3  = 3'b010;
    localparam logic [2:0] LS_BU_fn3 = 3'b100;
    localparam logic [2:0] LS_HU_fn3 = 3'b101;

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
`ifdef RCA_LS_STORE_TOKEN_EN
    localparam bit TOKEN_EN = 1'b1;
`else
    localparam bit TOKEN_EN = 1'b0;
`endif
    localparam bit USE_FIFO = !IS_STORE || TOKEN_EN;

    generate
        if (ACCESS_FN3 != LS_B_fn3 && ACCESS_FN3 != LS_H_fn3 && ACCESS_FN3 != LS_W_fn3 &&
            ACCESS_FN3 != LS_BU_fn3 && ACCESS_FN3 != LS_HU_fn3) begin : g_bad_fn3
            $error("ls_ou: illegal ACCESS_FN3");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_bad_depth
            $error("ls_ou: MAX_OUTSTANDING out of range 1..16");
        end
    endgenerate

    logic [CW-1:0]   credit_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   in_flight;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] mem [MAX_OUTSTANDING];
    logic            perr_q;
    logic            can_issue;
    logic            issue_ok;
    logic            credit_inc;
    logic            push;
    logic            pop;
    logic            unexpected;
    logic [XLEN-1:0] push_data;
    logic [XLEN-1:0] store_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign uses_data_in1 = 1'b1;
    assign uses_data_in2 = IS_STORE;
    assign fn3           = ACCESS_FN3;
    assign load          = !IS_STORE;
    assign store         = IS_STORE;
    assign addr          = data_in1;

    always_comb begin
        store_data = data_in2;
        case (ACCESS_FN3)
            LS_B_fn3, LS_BU_fn3: store_data = {{(XLEN-8){1'b0}}, data_in2[7:0]};
            LS_H_fn3, LS_HU_fn3: store_data = {{(XLEN-16){1'b0}}, data_in2[15:0]};
            default:             store_data = data_in2;
        endcase
    end

    always_comb begin
        can_issue = credit_cnt < MAX_CNT;
        in_flight = credit_cnt - fifo_count;
        // Without tokens a store never holds a credit, so the limit cannot apply.
        if (IS_STORE)
            issue_ok = data_valid_in1 && data_valid_in2 && !lsq_full && (can_issue || !TOKEN_EN);
        else
            issue_ok = data_valid_in1 && !lsq_full && can_issue;
        new_request    = rst && issue_ok;
        data_in_ack1   = new_request;
        data_in_ack2   = IS_STORE && new_request;
        data           = (IS_STORE && rst) ? store_data : '0;
        data_valid_out = rst && USE_FIFO && (fifo_count != '0);
        data_out       = data_valid_out ? mem[rd_ptr] : '0;
        pop            = data_valid_out && data_out_ack;
        credit_inc     = new_request && USE_FIFO;
        if (IS_STORE) begin
            push       = TOKEN_EN && new_request;
            push_data  = data_in1;
            unexpected = load_complete;
        end else begin
            push       = load_complete && (in_flight != '0);
            push_data  = load_data;
            unexpected = load_complete && (in_flight == '0);
        end
        protocol_err = rst && perr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_cnt <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            perr_q     <= 1'b0;
        end else begin
            case ({credit_inc, pop})
                2'b10:   credit_cnt <= credit_cnt + 1'b1;
                2'b01:   credit_cnt <= credit_cnt - 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (unexpected)
                perr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push && !pop)
            assert (fifo_count < MAX_CNT);
    end
endmodule

// File: tb/tb_ls_ou.sv
// tb/tb_ls_ou.sv - self-checking bench for ls_ou (load W/4 and store H/2 instances)
module tb_ls_ou;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        l_rst, l_v1, l_v2, l_oack, l_full, l_lc;
    logic [31:0] l_d1, l_d2, l_ld;
    logic        l_ack1, l_ack2, l_u1, l_u2, l_dvo, l_load, l_store, l_req, l_perr;
    logic [31:0] l_dout, l_addr, l_data;
    logic [2:0]  l_fn3;

    logic        s_rst, s_v1, s_v2, s_oack, s_full, s_lc;
    logic [31:0] s_d1, s_d2, s_ld;
    logic        s_ack1, s_ack2, s_u1, s_u2, s_dvo, s_load, s_store, s_req, s_perr;
    logic [31:0] s_dout, s_addr, s_data;
    logic [2:0]  s_fn3;

    ls_ou #(.XLEN(32), .IS_STORE(1'b0), .ACCESS_FN3(3'b010), .MAX_OUTSTANDING(4)) u_load (
        .clk(clk), .rst(l_rst), .data_in1(l_d1), .data_in2(l_d2),
        .data_valid_in1(l_v1), .data_valid_in2(l_v2), .data_in_ack1(l_ack1), .data_in_ack2(l_ack2),
        .uses_data_in1(l_u1), .uses_data_in2(l_u2), .data_out(l_dout), .data_valid_out(l_dvo),
        .data_out_ack(l_oack), .addr(l_addr), .data(l_data), .fn3(l_fn3), .load(l_load),
        .store(l_store), .new_request(l_req), .lsq_full(l_full), .load_data(l_ld),
        .load_complete(l_lc), .protocol_err(l_perr));

    ls_ou #(.XLEN(32), .IS_STORE(1'b1), .ACCESS_FN3(3'b001), .MAX_OUTSTANDING(2)) u_store (
        .clk(clk), .rst(s_rst), .data_in1(s_d1), .data_in2(s_d2),
        .data_valid_in1(s_v1), .data_valid_in2(s_v2), .data_in_ack1(s_ack1), .data_in_ack2(s_ack2),
        .uses_data_in1(s_u1), .uses_data_in2(s_u2), .data_out(s_dout), .data_valid_out(s_dvo),
        .data_out_ack(s_oack), .addr(s_addr), .data(s_data), .fn3(s_fn3), .load(s_load),
        .store(s_store), .new_request(s_req), .lsq_full(s_full), .load_data(s_ld),
        .load_complete(s_lc), .protocol_err(s_perr));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

`ifdef RCA_LS_STORE_TOKEN_EN
    localparam bit TOK = 1'b1;
`else
    localparam bit TOK = 1'b0;
`endif

    // Model: loads in flight, returned-but-unacked data, store tokens, sticky errors.
    int          l_out;
    logic [31:0] lq[$];
    logic [31:0] sq[$];
    bit          l_pe, s_pe;
    bit          le_req, se_req, lpop, spop, lret;
    logic [31:0] e_dout;

    always @(negedge clk) begin
        le_req = l_rst && l_v1 && !l_full && ((l_out + lq.size()) < 4);
        check("l_req", l_req, le_req);
        check("l_ack1", l_ack1, le_req);
        check("l_ack2", l_ack2, 0);
        check("l_dvo", l_dvo, l_rst && lq.size() > 0);
        e_dout = (l_rst && lq.size() > 0) ? lq[0] : 32'h0;
        check("l_dout", l_dout, e_dout);
        check("l_perr", l_perr, l_rst && l_pe);
        check("l_addr", l_addr, l_d1);
        check("l_const", {l_u1, l_u2, l_load, l_store, l_fn3}, 7'b1010010);

        se_req = s_rst && s_v1 && s_v2 && !s_full && (!TOK || sq.size() < 2);
        check("s_req", s_req, se_req);
        check("s_ack1", s_ack1, se_req);
        check("s_ack2", s_ack2, se_req);
        check("s_data", s_data, s_rst ? {16'h0, s_d2[15:0]} : 32'h0);
        check("s_addr", s_addr, s_d1);
        check("s_dvo", s_dvo, s_rst && sq.size() > 0);
        e_dout = (s_rst && sq.size() > 0) ? sq[0] : 32'h0;
        check("s_dout", s_dout, e_dout);
        check("s_perr", s_perr, s_rst && s_pe);
        check("s_const", {s_u1, s_u2, s_load, s_store, s_fn3}, 7'b1101001);

        if (!l_rst) begin
            l_out = 0; lq.delete(); l_pe = 0;
        end else begin
            lpop = l_oack && lq.size() > 0;
            lret = l_lc && l_out > 0;
            if (l_lc && l_out == 0) l_pe = 1;
            if (lpop) void'(lq.pop_front());
            if (lret) begin lq.push_back(l_ld); l_out--; end
            if (le_req) l_out++;
        end
        if (!s_rst) begin
            sq.delete(); s_pe = 0;
        end else begin
            spop = s_oack && sq.size() > 0;
            if (s_lc) s_pe = 1;
            if (spop) void'(sq.pop_front());
            if (se_req && TOK) sq.push_back(s_d1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int idx;
    int cnt;

    initial begin
        l_rst = 0; l_v1 = 0; l_v2 = 0; l_oack = 0; l_full = 0; l_lc = 0;
        l_d1 = 0; l_d2 = 0; l_ld = 0;
        s_rst = 0; s_v1 = 0; s_v2 = 0; s_oack = 0; s_full = 0; s_lc = 0;
        s_d1 = 0; s_d2 = 0; s_ld = 0;
        tick(); tick();
        @(negedge clk);
        check("rst_l_dvo", l_dvo, 0);
        check("rst_s_req", s_req, 0);
        tick();
        l_rst = 1; s_rst = 1;

        // Five back-to-back loads against a credit limit of four.
        idx = 0; l_d1 = 32'h100; l_v1 = 1;
        repeat (8) begin
            @(negedge clk);
            if (l_ack1) idx++;
            tick();
            l_d1 = 32'h100 + 32'(idx) * 4;
        end
        check("l_issued4", idx, 4);

        l_lc = 1; l_ld = 32'hDEADBEEF;
        tick();
        l_ld = 32'h12345678;
        @(negedge clk);
        check("l_first_valid", l_dvo, 1);
        check("l_first_data", l_dout, 32'hDEADBEEF);
        tick();
        l_lc = 0;
        @(negedge clk);
        check("l_head_hold", l_dout, 32'hDEADBEEF);
        check("l_fifth_held", l_req, 0);
        tick();
        l_oack = 1;
        tick();
        l_oack = 0;
        @(negedge clk);
        check("l_fifth_req", l_req, 1);
        check("l_fifth_addr", l_addr, 32'h110);
        check("l_second_data", l_dout, 32'h12345678);
        tick();
        l_v1 = 0; l_oack = 1;
        tick();
        l_oack = 0;
        @(negedge clk);
        check("l_drained", l_dvo, 0);

        // Unexpected completion with nothing in flight.
        tick();
        l_rst = 0;
        tick();
        l_rst = 1; l_lc = 1; l_ld = 32'hBAD0BAD0;
        tick();
        l_lc = 0;
        @(negedge clk);
        check("l_perr_set", l_perr, 1);
        check("l_perr_nopush", l_dvo, 0);
        tick(); tick(); tick();
        @(negedge clk);
        check("l_perr_sticky", l_perr, 1);
        tick();
        l_rst = 0;
        tick();
        l_rst = 1;
        @(negedge clk);
        check("l_perr_clear", l_perr, 0);

        // Store halfword held off by lsq_full.
        s_d1 = 32'h2000; s_d2 = 32'hAABBCCDD; s_v1 = 1; s_v2 = 1; s_full = 1; cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_req || s_ack1 || s_ack2) cnt++;
            tick();
        end
        check("s_full_stall", cnt, 0);
        s_full = 0;
        @(negedge clk);
        check("s_req_go", s_req, 1);
        check("s_data_h", s_data, 32'h0000CCDD);
        check("s_addr_go", s_addr, 32'h2000);
        check("s_acks", {s_ack1, s_ack2}, 2'b11);
        tick();
        s_v1 = 0; s_v2 = 0; s_rst = 0;
        tick();
        s_rst = 1;

        // Partial operand valid consumes nothing.
        s_d1 = 32'h3000; s_d2 = 32'h11223344; s_v1 = 1; cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_req || s_ack1 || s_ack2) cnt++;
            tick();
        end
        check("s_partial", cnt, 0);
        s_v2 = 1;
        @(negedge clk);
        check("s_partial_go", {s_req, s_ack1, s_ack2}, 3'b111);
        tick();
        s_v1 = 0; s_v2 = 0; s_rst = 0;
        tick();
        s_rst = 1;

        // Three stores against a token limit of two.
        idx = 0; s_d1 = 32'h40; s_v1 = 1; s_v2 = 1;
        repeat (6) begin
            @(negedge clk);
            if (s_ack1) idx++;
            tick();
            if (idx < 3) s_d1 = 32'h40 + 32'(idx) * 4;
            else begin s_v1 = 0; s_v2 = 0; end
        end
        check("s_accepted", idx, TOK ? 2 : 3);
`ifdef RCA_LS_STORE_TOKEN_EN
        @(negedge clk);
        check("s_tok0_valid", s_dvo, 1);
        check("s_tok0", s_dout, 32'h40);
        tick();
        s_oack = 1;
        @(negedge clk);
        check("s_third_held", s_req, 0);
        tick();
        s_oack = 0;
        @(negedge clk);
        check("s_third_req", s_req, 1);
        check("s_third_addr", s_addr, 32'h48);
        check("s_tok1", s_dout, 32'h44);
        tick();
        s_v1 = 0; s_v2 = 0;
`else
        @(negedge clk);
        check("s_no_token_valid", s_dvo, 0);
        check("s_no_token_data", s_dout, 0);
        tick();
`endif
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
